// File: rtl/muldiv_if.sv
// Handshake and result bundle between the issuing core and muldiv_unit.
// master: core side (issues operations); slave: muldiv_unit side.
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [4:0]       lo_dst;
  logic [4:0]       hi_dst;
  logic             busy;
  logic             done;
  logic             we;
  logic [4:0]       w1_out;
  logic [4:0]       w2_out;
  logic [WIDTH-1:0] dout1;
  logic [WIDTH-1:0] dout2;
  logic             div_by_zero;

  modport master (
    output start, op, a, b, lo_dst, hi_dst,
    input  busy, done, we, w1_out, w2_out, dout1, dout2, div_by_zero
  );

  modport slave (
    input  start, op, a, b, lo_dst, hi_dst,
    output busy, done, we, w1_out, w2_out, dout1, dout2, div_by_zero
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: one shift-add or restoring-subtract step per cycle.
// Define MULDIV_DIV_EN to build the divider; otherwise DIV/DIVU complete with zero results.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic      clk,
  input  logic      rst_n,
  muldiv_if.slave   bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  logic             is_div_q;
  logic             neg_lo_q;
  logic [WIDTH-1:0] md_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [4:0]       lo_dst_q;
  logic [4:0]       hi_dst_q;
`ifdef MULDIV_DIV_EN
  logic             neg_hi_q;
  logic             dz_q;
  logic [WIDTH-1:0] a_q;
`endif

  logic             is_signed;
  logic             sign_a;
  logic             sign_b;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] res_lo;
  logic [WIDTH-1:0] res_hi;
  logic             res_dz;

  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v,
                                                 input logic is_neg);
    return is_neg ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic n);
    return n ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] v, input logic n);
    return n ? (~v + 1'b1) : v;
  endfunction

  assign is_signed = ~bus.op[0];
  assign sign_a    = is_signed & bus.a[WIDTH-1];
  assign sign_b    = is_signed & bus.b[WIDTH-1];

  // hi_q accumulates the product's upper half while lo_q shifts the multiplier out
  assign mul_sum = {1'b0, hi_q} + {1'b0, (lo_q[0] ? md_q : {WIDTH{1'b0}})};

`ifdef MULDIV_DIV_EN
  logic [WIDTH:0]   div_shift;
  logic [WIDTH+1:0] div_diff;
  logic             div_borrow;

  // hi_q is the partial remainder, lo_q shifts the dividend out and the quotient in
  assign div_shift  = {hi_q, lo_q[WIDTH-1]};
  assign div_diff   = {1'b0, div_shift} - {2'b00, md_q};
  assign div_borrow = div_diff[WIDTH+1];
`endif

  always_comb begin
    res_lo = '0;
    res_hi = '0;
    res_dz = 1'b0;
    if (!is_div_q) begin
      {res_hi, res_lo} = cond_neg2({hi_q, lo_q}, neg_lo_q);
    end else begin
`ifdef MULDIV_DIV_EN
      if (dz_q) begin
        res_lo = '1;
        res_hi = a_q;
        res_dz = 1'b1;
      end else begin
        res_lo = cond_neg(lo_q, neg_lo_q);
        res_hi = cond_neg(hi_q, neg_hi_q);
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && bus.start) begin
      is_div_q <= bus.op[1];
      neg_lo_q <= sign_a ^ sign_b;
      hi_q     <= '0;
      lo_q     <= magnitude(bus.a, sign_a);
      md_q     <= magnitude(bus.b, sign_b);
      lo_dst_q <= bus.lo_dst;
      hi_dst_q <= bus.hi_dst;
`ifdef MULDIV_DIV_EN
      neg_hi_q <= sign_a;
      dz_q     <= (bus.b == '0);
      a_q      <= bus.a;
`endif
    end else if (state == RUN) begin
      if (!is_div_q) begin
        {hi_q, lo_q} <= {mul_sum, lo_q[WIDTH-1:1]};
      end
`ifdef MULDIV_DIV_EN
      else begin
        hi_q <= div_borrow ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
        lo_q <= {lo_q[WIDTH-2:0], ~div_borrow};
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      cnt             <= '0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.we          <= 1'b0;
      bus.div_by_zero <= 1'b0;
      bus.dout1       <= '0;
      bus.dout2       <= '0;
      bus.w1_out      <= '0;
      bus.w2_out      <= '0;
    end else begin
      bus.done <= 1'b0;
      bus.we   <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state    <= RUN;
            cnt      <= '0;
            bus.busy <= 1'b1;
          end
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST_STEP) state <= DONE;
        end
        DONE: begin
          // signs are applied here, on the accumulated magnitudes
          state           <= IDLE;
          bus.busy        <= 1'b0;
          bus.done        <= 1'b1;
          bus.we          <= 1'b1;
          bus.dout1       <= res_lo;
          bus.dout2       <= res_hi;
          bus.div_by_zero <= res_dz;
          bus.w1_out      <= lo_dst_q;
          bus.w2_out      <= hi_dst_q;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized and directed bench for muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;

  localparam int WIDTH = 32;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  muldiv_if #(.WIDTH(WIDTH)) bus ();

  muldiv_unit #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic void ref_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] lo, output logic [31:0] hi,
                                    output logic dz);
    longint      sp;
    logic [63:0] up;
    longint      sa, sb, q, r;
    lo = '0;
    hi = '0;
    dz = 1'b0;
    case (op)
      2'b00: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        lo = sp[31:0];
        hi = sp[63:32];
      end
      2'b01: begin
        up = {32'd0, a} * {32'd0, b};
        lo = up[31:0];
        hi = up[63:32];
      end
      default: begin
`ifdef MULDIV_DIV_EN
        if (b == 32'd0) begin
          lo = 32'hFFFF_FFFF;
          hi = a;
          dz = 1'b1;
        end else if (op == 2'b10) begin
          sa = longint'($signed(a));
          sb = longint'($signed(b));
          q  = sa / sb;
          r  = sa % sb;
          lo = q[31:0];
          hi = r[31:0];
        end else begin
          lo = a / b;
          hi = a % b;
        end
`endif
      end
    endcase
  endfunction

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] ld, input logic [4:0] hd, input bit release_rst);
    @(negedge clk);
    if (release_rst) rst_n = 1'b1;
    bus.start  = 1'b1;
    bus.op     = op;
    bus.a      = a;
    bus.b      = b;
    bus.lo_dst = ld;
    bus.hi_dst = hd;
    @(posedge clk);
    #1;
    bus.start  = 1'b0;
    bus.op     = 2'($urandom);
    bus.a      = $urandom;
    bus.b      = $urandom;
    bus.lo_dst = 5'($urandom);
    bus.hi_dst = 5'($urandom);
  endtask

  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] ld, input logic [4:0] hd,
                       input bit inject_start, input bit release_rst);
    logic [31:0] e_lo, e_hi;
    logic        e_dz;
    int          lat;
    int          extra;
    ref_model(op, a, b, e_lo, e_hi, e_dz);
    issue(op, a, b, ld, hd, release_rst);
    check("busy_run", 64'(bus.busy), 64'd1);
    lat = -1;
    for (int k = 1; k <= WIDTH + 4; k++) begin
      @(posedge clk);
      #1;
      bus.start = inject_start && (k == 4 || k == 32);
      if (bus.start) begin
        bus.a = $urandom;
        bus.b = $urandom;
      end
      if (bus.done) begin
        lat = k;
        break;
      end
    end
    bus.start = 1'b0;
    check("latency", 64'(lat), 64'(WIDTH + 1));
    check("we", 64'(bus.we), 64'd1);
    check("dout1", 64'(bus.dout1), 64'(e_lo));
    check("dout2", 64'(bus.dout2), 64'(e_hi));
    check("dz", 64'(bus.div_by_zero), 64'(e_dz));
    check("w1", 64'(bus.w1_out), 64'(ld));
    check("w2", 64'(bus.w2_out), 64'(hd));
    @(posedge clk);
    #1;
    check("we_after", 64'(bus.we), 64'd0);
    check("hold_dout1", 64'(bus.dout1), 64'(e_lo));
    if (inject_start) begin
      extra = 0;
      for (int k = 0; k < WIDTH + 8; k++) begin
        @(posedge clk);
        #1;
        if (bus.done) extra++;
      end
      check("no_second_done", 64'(extra), 64'd0);
      check("hold_dout2", 64'(bus.dout2), 64'(e_hi));
    end
  endtask

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    int          we_seen;
    n_checks   = 0;
    n_pass     = 0;
    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.op     = 2'b00;
    bus.a      = '0;
    bus.b      = '0;
    bus.lo_dst = '0;
    bus.hi_dst = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_dout", {bus.dout2, bus.dout1}, 64'd0);

    // first start on the very first edge after reset release
    do_op(2'b01, 32'hFFFF_FFFF, 32'd2, 5'd5, 5'd6, 1'b0, 1'b1);
    do_op(2'b00, 32'hFFFF_FFFD, 32'd7, 5'd1, 5'd2, 1'b0, 1'b0);
    do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 5'd3, 5'd4, 1'b0, 1'b0);
    do_op(2'b11, 32'd7, 32'd2, 5'd7, 5'd8, 1'b0, 1'b0);
    do_op(2'b11, 32'h0000_1234, 32'd0, 5'd9, 5'd10, 1'b0, 1'b0);
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 5'd12, 1'b0, 1'b0);
    do_op(2'b10, 32'hFFFF_FF00, 32'd0, 5'd13, 5'd14, 1'b0, 1'b0);
    do_op(2'b00, 32'h8000_0000, 32'h8000_0000, 5'd15, 5'd16, 1'b0, 1'b0);
    do_op(2'b01, 32'h1234_5678, 32'h9ABC_DEF0, 5'd17, 5'd18, 1'b1, 1'b0);

    for (int i = 0; i < 24; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 300));
        2:       rb = -32'($urandom_range(1, 300));
        default: rb = $urandom;
      endcase
      do_op(rop, ra, rb, 5'($urandom), 5'($urandom), 1'b0, 1'b0);
    end

    // abort in the middle of a run
    issue(2'b00, 32'd1234, 32'd5678, 5'd20, 5'd21, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_dout", {bus.dout2, bus.dout1}, 64'd0);
    check("abort_ctl", {59'd0, bus.busy, bus.done, bus.we, bus.div_by_zero, 1'b0}, 64'd0);
    check("abort_dst", {54'd0, bus.w1_out, bus.w2_out}, 64'd0);
    we_seen = 0;
    for (int k = 0; k < WIDTH + 4; k++) begin
      @(posedge clk);
      #1;
      if (bus.we) we_seen++;
    end
    check("abort_no_we", 64'(we_seen), 64'd0);
    do_op(2'b01, 32'd1000, 32'd3000, 5'd22, 5'd23, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
